// File: rtl/l2_controller.sv
// L1-to-L2 read responder: 2-way set-associative tag/valid/LRU array with
// memory refill on miss. Control only; the data array follows refill_L2/way_L2.
module l2_controller #(
    parameter int TNUM_2  = 18,
    parameter int INUM_2  = 8,
    parameter int HIT_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_L1_L2,
    input  logic [TNUM_2-1:0] tag_L1_L2,
    input  logic [INUM_2-1:0] index_L1_L2,
    input  logic              flush,
    input  logic              ready_MEM_L2,
    output logic              ready_L2_L1,
    output logic              read_L2_MEM,
    output logic [TNUM_2-1:0] tag_L2_MEM,
    output logic [INUM_2-1:0] index_L2_MEM,
    output logic              refill_L2,
    output logic              way_L2,
    output logic              busy
);

    // state    | meaning
    // IDLE     | waiting for a read; applies live or pending flush
    // COMPARE  | tag lookup, hit/victim way selected
    // HIT_WAIT | down-counting the hit latency
    // MEM_REQ  | read_L2_MEM held until memory returns the block
    // REFILL   | one-cycle data-array write, tag/valid/LRU update
    // RESP     | one-cycle ready_L2_L1 pulse
    // DONE     | lets L1 drop its request before the next capture
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] COMPARE  = 3'd1;
    localparam logic [2:0] HIT_WAIT = 3'd2;
    localparam logic [2:0] MEM_REQ  = 3'd3;
    localparam logic [2:0] REFILL   = 3'd4;
    localparam logic [2:0] RESP     = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;

    localparam int SETS = 1 << INUM_2;
    localparam int CW   = (HIT_LAT > 1) ? $clog2(HIT_LAT) : 1;

    logic [2:0]        state, state_nxt;
    logic [CW-1:0]     cnt;
    logic              way_q;
    logic              flush_pend;
    logic [SETS-1:0]   valid0, valid1, lru;
    logic [TNUM_2-1:0] tags0 [SETS];
    logic [TNUM_2-1:0] tags1 [SETS];

    logic hit0, hit1, hit, hit_way, victim, cmp_way, flush_now;

    // tag_L2_MEM/index_L2_MEM double as the latched request address
    assign hit0      = valid0[index_L2_MEM] && (tags0[index_L2_MEM] == tag_L2_MEM);
    assign hit1      = valid1[index_L2_MEM] && (tags1[index_L2_MEM] == tag_L2_MEM);
    assign hit       = hit0 | hit1;
    assign hit_way   = ~hit0;
    assign victim    = !valid0[index_L2_MEM] ? 1'b0 :
                       !valid1[index_L2_MEM] ? 1'b1 : lru[index_L2_MEM];
    assign cmp_way   = hit ? hit_way : victim;
    assign flush_now = flush | flush_pend;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (!flush_now && read_L1_L2) state_nxt = COMPARE;
            COMPARE:  state_nxt = hit ? HIT_WAIT : MEM_REQ;
            HIT_WAIT: if (cnt == '0) state_nxt = RESP;
            MEM_REQ:  if (ready_MEM_L2) state_nxt = REFILL;
            REFILL:   state_nxt = RESP;
            RESP:     state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            way_q        <= 1'b0;
            flush_pend   <= 1'b0;
            valid0       <= '0;
            valid1       <= '0;
            lru          <= '0;
            tag_L2_MEM   <= '0;
            index_L2_MEM <= '0;
            ready_L2_L1  <= 1'b0;
            read_L2_MEM  <= 1'b0;
            refill_L2    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy        <= (state_nxt != IDLE);
            ready_L2_L1 <= (state_nxt == RESP);
            read_L2_MEM <= (state_nxt == MEM_REQ);
            refill_L2   <= (state_nxt == REFILL);
            if (state != IDLE && flush)
                flush_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (flush_now) begin
                        valid0     <= '0;
                        valid1     <= '0;
                        lru        <= '0;
                        flush_pend <= 1'b0;
                    end else if (read_L1_L2) begin
                        tag_L2_MEM   <= tag_L1_L2;
                        index_L2_MEM <= index_L1_L2;
                    end
                end
                COMPARE: begin
                    way_q <= cmp_way;
                    cnt   <= CW'(HIT_LAT - 1);
                    if (hit)
                        lru[index_L2_MEM] <= ~hit_way;
                end
                HIT_WAIT: begin
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                end
                REFILL: begin
                    if (way_q) valid1[index_L2_MEM] <= 1'b1;
                    else       valid0[index_L2_MEM] <= 1'b1;
                    lru[index_L2_MEM] <= ~way_q;
                end
                default: ;
            endcase
        end
    end

    // Tag storage needs no reset: every entry is qualified by its valid bit
    always_ff @(posedge clk) begin
        if (state == REFILL) begin
            if (way_q) tags1[index_L2_MEM] <= tag_L2_MEM;
            else       tags0[index_L2_MEM] <= tag_L2_MEM;
        end
    end

    always_comb begin
        way_L2 = 1'b0;
        if (state == COMPARE)
            way_L2 = cmp_way;
        else if (state == HIT_WAIT || state == MEM_REQ || state == REFILL || state == RESP)
            way_L2 = way_q;
    end

endmodule

// File: tb/tb_l2_controller.sv
// Self-checking bench for l2_controller: directed scenarios plus random
// traffic scored against a per-set behavioural cache model.
module tb_l2_controller;

    localparam int TNUM_2  = 18;
    localparam int INUM_2  = 8;
    localparam int HIT_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              read_L1_L2 = 1'b0;
    logic [TNUM_2-1:0] tag_L1_L2 = '0;
    logic [INUM_2-1:0] index_L1_L2 = '0;
    logic              flush = 1'b0;
    logic              ready_MEM_L2 = 1'b0;
    logic              ready_L2_L1, read_L2_MEM, refill_L2, way_L2, busy;
    logic [TNUM_2-1:0] tag_L2_MEM;
    logic [INUM_2-1:0] index_L2_MEM;

    int checks = 0;
    int errors = 0;

    bit                m_valid0 [256];
    bit                m_valid1 [256];
    bit                m_lru    [256];
    logic [TNUM_2-1:0] m_tag0   [256];
    logic [TNUM_2-1:0] m_tag1   [256];
    bit                pend_tb = 1'b0;

    l2_controller #(.TNUM_2(TNUM_2), .INUM_2(INUM_2), .HIT_LAT(HIT_LAT)) dut (
        .clk(clk), .rst(rst), .read_L1_L2(read_L1_L2), .tag_L1_L2(tag_L1_L2),
        .index_L1_L2(index_L1_L2), .flush(flush), .ready_MEM_L2(ready_MEM_L2),
        .ready_L2_L1(ready_L2_L1), .read_L2_MEM(read_L2_MEM), .tag_L2_MEM(tag_L2_MEM),
        .index_L2_MEM(index_L2_MEM), .refill_L2(refill_L2), .way_L2(way_L2), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic void model_clear();
        for (int i = 0; i < 256; i++) begin
            m_valid0[i] = 1'b0;
            m_valid1[i] = 1'b0;
            m_lru[i]    = 1'b0;
        end
    endfunction

    // One L1 read, from request to the DONE cycle, with memory emulation.
    task automatic do_read(input logic [TNUM_2-1:0] t, input logic [INUM_2-1:0] ix,
                           input int lat, input bit flush_with, input bit flush_mid,
                           input bit keep, output bit got_hit, output bit got_way,
                           output int waited);
        bit exp_hit, exp_way, ready_way, refill_way, flushed_mid, addr_bad;
        int k, idle_cycles, exp_idle, memreq_k, mcnt, refill_cnt, refill_k, ready_k;
        read_L1_L2  = 1'b1;
        tag_L1_L2   = t;
        index_L1_L2 = ix;
        waited = 0;
        while (busy === 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        exp_idle = (flush_with || pend_tb) ? 2 : 1;
        if (flush_with || pend_tb) model_clear();
        pend_tb = 1'b0;
        if (m_valid0[ix] && m_tag0[ix] == t) begin
            exp_hit = 1'b1; exp_way = 1'b0;
        end else if (m_valid1[ix] && m_tag1[ix] == t) begin
            exp_hit = 1'b1; exp_way = 1'b1;
        end else begin
            exp_hit = 1'b0;
            exp_way = !m_valid0[ix] ? 1'b0 : (!m_valid1[ix] ? 1'b1 : m_lru[ix]);
        end
        if (flush_with) flush = 1'b1;
        idle_cycles = 0;
        do begin
            @(negedge clk);
            flush = 1'b0;
            idle_cycles++;
        end while (busy !== 1'b1 && idle_cycles < 10);
        checks++;
        if (idle_cycles != exp_idle) begin
            errors++;
            $display("FAIL capture_delay tag=%h idx=%h: got %0d cycles, expected %0d", t, ix, idle_cycles, exp_idle);
        end
        checks++;
        if (way_L2 !== exp_way) begin
            errors++;
            $display("FAIL compare_way tag=%h idx=%h: got %b, expected %b", t, ix, way_L2, exp_way);
        end
        k = 1; memreq_k = 0; mcnt = 0; refill_cnt = 0; refill_k = 0; ready_k = 0;
        flushed_mid = 1'b0; addr_bad = 1'b0; ready_way = 1'b0; refill_way = 1'b0;
        while (k < 300) begin
            if (read_L2_MEM === 1'b1) begin
                if (memreq_k == 0) memreq_k = k;
                if (tag_L2_MEM !== t || index_L2_MEM !== ix) addr_bad = 1'b1;
                mcnt++;
                if (mcnt == lat) ready_MEM_L2 = 1'b1;
                if (flush_mid && !flushed_mid) begin
                    flush = 1'b1;
                    flushed_mid = 1'b1;
                end
            end
            if (refill_L2 === 1'b1) begin
                refill_cnt++;
                refill_k = k;
                refill_way = way_L2;
            end
            if (ready_L2_L1 === 1'b1) begin
                ready_k = k;
                ready_way = way_L2;
                break;
            end
            @(negedge clk);
            k++;
            ready_MEM_L2 = 1'b0;
            flush = 1'b0;
        end
        read_L1_L2 = keep;
        checks++;
        if (ready_k == 0) begin
            errors++;
            $display("FAIL ready_timeout tag=%h idx=%h: no ready_L2_L1 within 300 cycles", t, ix);
        end
        if (exp_hit) begin
            checks++;
            if (ready_k != HIT_LAT + 2) begin
                errors++;
                $display("FAIL hit_latency tag=%h: ready at obs %0d, expected %0d", t, ready_k, HIT_LAT + 2);
            end
            checks++;
            if (memreq_k != 0 || refill_cnt != 0) begin
                errors++;
                $display("FAIL hit_no_mem tag=%h: memreq at %0d refills %0d, expected none", t, memreq_k, refill_cnt);
            end
        end else begin
            checks++;
            if (memreq_k != 2) begin
                errors++;
                $display("FAIL memreq_start tag=%h: read_L2_MEM at obs %0d, expected 2", t, memreq_k);
            end
            checks++;
            if (addr_bad) begin
                errors++;
                $display("FAIL mem_addr: got tag %h idx %h, expected tag %h idx %h", tag_L2_MEM, index_L2_MEM, t, ix);
            end
            checks++;
            if (refill_cnt != 1 || refill_way !== exp_way) begin
                errors++;
                $display("FAIL refill tag=%h: %0d refills way %b, expected 1 refill way %b", t, refill_cnt, refill_way, exp_way);
            end
            checks++;
            if (ready_k != refill_k + 1) begin
                errors++;
                $display("FAIL refill_to_ready tag=%h: ready at %0d, expected %0d", t, ready_k, refill_k + 1);
            end
        end
        checks++;
        if (ready_way !== exp_way) begin
            errors++;
            $display("FAIL resp_way tag=%h: got %b, expected %b", t, ready_way, exp_way);
        end
        @(negedge clk);
        checks++;
        if (ready_L2_L1 !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ready_pulse: ready=%b busy=%b after response, expected ready=0 busy=1", ready_L2_L1, busy);
        end
        if (!exp_hit) begin
            if (exp_way) begin m_valid1[ix] = 1'b1; m_tag1[ix] = t; end
            else         begin m_valid0[ix] = 1'b1; m_tag0[ix] = t; end
        end
        m_lru[ix] = ~exp_way;
        if (flushed_mid) pend_tb = 1'b1;
        got_hit = (memreq_k == 0);
        got_way = ready_way;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({ready_L2_L1, read_L2_MEM, refill_L2, way_L2, busy} !== 5'b0 ||
            tag_L2_MEM !== '0 || index_L2_MEM !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b rd=%b rf=%b way=%b busy=%b, expected all 0",
                     ready_L2_L1, read_L2_MEM, refill_L2, way_L2, busy);
        end
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_miss_hit();
        bit h, w; int wt;
        do_read(18'h12345, 8'h05, 10, 0, 0, 0, h, w, wt);
        checks++;
        if (h !== 1'b0 || w !== 1'b0) begin
            errors++; $display("FAIL cold_miss: hit=%b way=%b, expected miss way 0", h, w);
        end
        do_read(18'h12345, 8'h05, 3, 0, 0, 0, h, w, wt);
        checks++;
        if (h !== 1'b1 || w !== 1'b0) begin
            errors++; $display("FAIL first_hit: hit=%b way=%b, expected hit way 0", h, w);
        end
    endtask

    task automatic test_second_way_replacement();
        bit h, w; int wt;
        do_read(18'h0ABCD, 8'h05, 4, 0, 0, 0, h, w, wt);
        checks++;
        if (h !== 1'b0 || w !== 1'b1) begin
            errors++; $display("FAIL second_way: hit=%b way=%b, expected miss way 1", h, w);
        end
        do_read(18'h12345, 8'h05, 4, 0, 0, 0, h, w, wt);
        checks++;
        if (h !== 1'b1 || w !== 1'b0) begin
            errors++; $display("FAIL reread_way0: hit=%b way=%b, expected hit way 0", h, w);
        end
        do_read(18'h00777, 8'h05, 2, 0, 0, 0, h, w, wt);
        checks++;
        if (h !== 1'b0 || w !== 1'b1) begin
            errors++; $display("FAIL lru_victim: hit=%b way=%b, expected miss way 1", h, w);
        end
        do_read(18'h0ABCD, 8'h05, 2, 0, 0, 0, h, w, wt);
        checks++;
        if (h !== 1'b0 || w !== 1'b0) begin
            errors++; $display("FAIL evicted_miss: hit=%b way=%b, expected miss way 0", h, w);
        end
    endtask

    task automatic test_flush();
        bit h, w; int wt;
        while (busy === 1'b1) @(negedge clk);
        read_L1_L2 = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL flush_idle_busy: busy=%b, expected 0", busy);
        end
        do_read(18'h12345, 8'h05, 2, 0, 0, 0, h, w, wt);
        checks++;
        if (h !== 1'b0 || w !== 1'b0) begin
            errors++; $display("FAIL flush_miss: hit=%b way=%b, expected miss way 0", h, w);
        end
        do_read(18'h12345, 8'h05, 2, 1, 0, 0, h, w, wt);
        checks++;
        if (h !== 1'b0) begin
            errors++; $display("FAIL flush_with_read: hit=%b, expected miss", h);
        end
        do_read(18'h0ABCD, 8'h05, 5, 0, 1, 0, h, w, wt);
        checks++;
        if (h !== 1'b0 || w !== 1'b1) begin
            errors++; $display("FAIL flush_mid_txn: hit=%b way=%b, expected miss way 1", h, w);
        end
        do_read(18'h0ABCD, 8'h05, 2, 0, 0, 0, h, w, wt);
        checks++;
        if (h !== 1'b0) begin
            errors++; $display("FAIL pending_flush: hit=%b, expected miss", h);
        end
    endtask

    task automatic test_back_to_back();
        bit h, w; int wt;
        do_read(18'h00111, 8'h07, 2, 0, 0, 1, h, w, wt);
        do_read(18'h00222, 8'h09, 2, 0, 0, 1, h, w, wt);
        checks++;
        if (wt != 1) begin
            errors++; $display("FAIL b2b_gap: waited %0d cycles in DONE, expected 1", wt);
        end
        do_read(18'h00111, 8'h07, 2, 0, 0, 0, h, w, wt);
        checks++;
        if (h !== 1'b1 || wt != 1) begin
            errors++; $display("FAIL b2b_hit: hit=%b waited=%0d, expected hit and 1", h, wt);
        end
    endtask

    task automatic test_reset_mid();
        bit h, w; int wt, n;
        bit bad;
        do_read(18'h12345, 8'h05, 2, 0, 0, 0, h, w, wt);
        while (busy === 1'b1) @(negedge clk);
        read_L1_L2 = 1'b1; tag_L1_L2 = 18'h3C3C3; index_L1_L2 = 8'h05;
        n = 0;
        while (read_L2_MEM !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (read_L2_MEM !== 1'b0 || busy !== 1'b0 || ready_L2_L1 !== 1'b0 || n >= 20) begin
            errors++;
            $display("FAIL reset_mid: rd=%b busy=%b rdy=%b (n=%0d), expected all 0 after MEM_REQ",
                     read_L2_MEM, busy, ready_L2_L1, n);
        end
        read_L1_L2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        pend_tb = 1'b0;
        ready_MEM_L2 = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ready_MEM_L2 = 1'b0;
            if (busy !== 1'b0 || refill_L2 !== 1'b0 || ready_L2_L1 !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL stray_mem_ready: busy=%b refill=%b, expected 0", busy, refill_L2);
        end
        do_read(18'h12345, 8'h05, 2, 0, 0, 0, h, w, wt);
        checks++;
        if (h !== 1'b0) begin
            errors++; $display("FAIL reset_invalidates: hit=%b, expected miss", h);
        end
    endtask

    task automatic test_random();
        bit h, w; int wt;
        logic [TNUM_2-1:0] pool [4];
        logic [INUM_2-1:0] t_idx;
        pool[0] = 18'h00001; pool[1] = 18'h2F00D; pool[2] = 18'h15555; pool[3] = 18'h3FFFF;
        for (int i = 0; i < 80; i++) begin
            t_idx = INUM_2'($urandom_range(1, 3));
            do_read(pool[$urandom_range(0, 3)], t_idx, $urandom_range(1, 6),
                    ($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) == 0), h, w, wt);
        end
        read_L1_L2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_miss_hit();
        test_second_way_replacement();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_controller.md
Name: L2_controller

Overview:
- Responder-side controller for the L1-to-L2 read interface.
- Accepts block read requests (read_L1_L2, tag_L1_L2, index_L1_L2) from the L1 instruction cache controller and answers each one with a single-cycle ready_L2_L1 pulse.
- Holds a 2-way set-associative L2 tag/valid/LRU array; on an L2 miss it fetches the block from memory through a req/ready handshake and refills.
- Control only; the data array is driven by refill_L2 and way_L2.

Parameters:
- TNUM_2, 18, number of L2 tag bits.
- INUM_2, 8, number of L2 index bits (2^INUM_2 sets); TNUM_2 + INUM_2 = 26, the block address.
- HIT_LAT, 2, extra cycles from COMPARE to response on a hit; must be at least 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- read_L1_L2  input  1  L1 read request; held high by L1 until ready_L2_L1.
- tag_L1_L2  input  TNUM_2  requested tag.
- index_L1_L2  input  INUM_2  requested index.
- flush  input  1  invalidate all L2 lines.
- ready_MEM_L2  input  1  memory has returned the block.
- ready_L2_L1  output  1  one-cycle response pulse to L1.
- read_L2_MEM  output  1  memory read request.
- tag_L2_MEM  output  TNUM_2  latched tag of the miss.
- index_L2_MEM  output  INUM_2  latched index of the miss.
- refill_L2  output  1  one-cycle write enable for the data array.
- way_L2  output  1  way being read (hit) or refilled (miss).
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst=1): FSM goes to IDLE; all outputs 0; all valid and LRU bits 0. Reset mid-transaction aborts it with no response and no refill.
- States: IDLE, COMPARE, HIT_WAIT, MEM_REQ, REFILL, RESP, DONE.
- IDLE:
  - If flush=1: clear all valid and LRU bits on this edge; read_L1_L2 is not captured this cycle. Flush has priority over a read.
  - Else if read_L1_L2=1: latch tag and index (the capture edge), go to COMPARE.
- COMPARE (1 cycle):
  - Hit: valid[w][idx] set and tag[w][idx] equals the latched tag. way_L2 = hit way; lru[idx] is set to the other way (~hit way). Go to HIT_WAIT with counter = HIT_LAT-1.
  - Miss: choose the victim in this order: invalid way0, else invalid way1, else lru[idx]. way_L2 = victim. Go to MEM_REQ.
- HIT_WAIT: decrement the counter; at 0 go to RESP.
- Hit latency: ready_L2_L1 is high exactly HIT_LAT+1 cycles after the capture edge.
- MEM_REQ:
  - read_L2_MEM=1; tag_L2_MEM and index_L2_MEM hold the latched address, stable for the whole request.
  - Held until ready_MEM_L2 is sampled high; next state is REFILL.
  - ready_MEM_L2 is ignored in every other state.
- REFILL (1 cycle): refill_L2=1 with way_L2=victim. Write the tag, set valid, set lru[idx] = ~victim. Go to RESP.
- RESP (1 cycle): ready_L2_L1=1; way_L2 is held. Go to DONE.
- DONE (1 cycle): read_L1_L2 is ignored so the L1 can deassert; go to IDLE. A back-to-back request is captured at the earliest 2 cycles after the ready pulse.
- flush while busy: set a pending bit. The current transaction completes normally; the flush is applied in the first IDLE cycle with the same priority as a live flush. The pending bit clears when applied.
- Request inputs are sampled only in IDLE; changes while busy have no effect.
- Outputs are registered, not combinational from inputs, except way_L2, which is valid from COMPARE through RESP.
- Only one transaction is outstanding; there is no queueing.

Test Plan:
1. Cold miss: after reset, request tag=0x12345, index=0x05; ready_MEM_L2 pulses 10 cycles after read_L2_MEM rises.
   -> read_L2_MEM rises the cycle after COMPARE with tag_L2_MEM=0x12345, index_L2_MEM=0x05.
   -> One refill_L2 cycle with way_L2=0, then a one-cycle ready_L2_L1.
2. Hit: repeat the same request.
   -> ready_L2_L1 high exactly 3 cycles after the capture edge (HIT_LAT=2), way_L2=0.
   -> read_L2_MEM and refill_L2 stay 0.
3. Second way: tag=0x0ABCD, index=0x05 -> miss, refill with way_L2=1. Re-read tag 0x12345 -> hit way0, so lru[0x05] points to way1.
4. Replacement: tag=0x00777, index=0x05 -> miss, victim way1. Re-read tag 0x0ABCD -> miss.
5. Flush:
   -> Hold flush in IDLE for 1 cycle; all previously filled lines then miss.
   -> Assert flush during MEM_REQ: the current transaction completes with ready_L2_L1, then the flush is applied.
   -> A read presented in the same IDLE cycle as the flush is captured one cycle later.
6. Reset mid-miss: assert rst while in MEM_REQ.
   -> read_L2_MEM, busy and ready_L2_L1 drop to 0 immediately (async).
   -> A later ready_MEM_L2 is ignored, and the previously valid tag at 0x05 now misses.
